// File: rtl/lsu_dmem_master.sv
// Load/store unit for the MEM stage. It drives a word-wide data memory that
// has a combinational read and a posedge write. It handles RV32I byte, half
// and word accesses: lane selection, sign/zero extension, read-modify-write
// for sub-word stores, and alignment, range and funct3 legality checks.
module lsu_dmem_master #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    RMW,
    RESP
  } state_t;

  // Word-index limit; comparing addr[31:2] against it is the same as
  // comparing the full byte address against 4*MEM_WORDS.
  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_t      state;
  state_t      state_next;
  logic [31:0] rdata_q;
  logic [31:0] rdata_next;
  logic        err_q;
  logic        err_next;
  logic [31:0] addr_q;
  logic [31:0] addr_next;
  logic [31:0] merged_q;
  logic [31:0] merged_next;
  logic        we_raw;

  logic        bad_funct3;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged_word;

  // Classify the incoming request: illegal funct3, misalignment, range.
  always_comb begin
    bad_funct3   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr[31:2] >= WORD_LIMIT);
    req_err      = bad_funct3 || misaligned || out_of_range;
  end

  // Select the addressed lane of the read word and extend it for loads.
  always_comb begin
    lane_byte = mem_rd[{req_addr[1:0], 3'b000} +: 8];
    lane_half = mem_rd[{req_addr[1], 4'b0000} +: 16];
    case (req_funct3)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b010:  load_val = mem_rd;
      3'b100:  load_val = {24'h000000, lane_byte};
      3'b101:  load_val = {16'h0000, lane_half};
      default: load_val = 32'h0;
    endcase
  end

  // Merge the store byte or half into the current word for sub-word stores.
  always_comb begin
    merged_word = mem_rd;
    if (req_funct3[1:0] == 2'b00) begin
      merged_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    end else begin
      merged_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end
  end

  // Next-state and output decode for the IDLE / RMW / RESP sequence.
  always_comb begin
    state_next  = state;
    rdata_next  = rdata_q;
    err_next    = err_q;
    addr_next   = addr_q;
    merged_next = merged_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_a       = addr_q;
    mem_wd      = merged_q;
    we_raw      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        mem_a     = {req_addr[31:2], 2'b00};
        mem_wd    = req_wdata;
        if (req_valid) begin
          if (req_err) begin
            rdata_next = 32'h0;
            err_next   = 1'b1;
            state_next = RESP;
          end else if (!req_we) begin
            rdata_next = load_val;
            err_next   = 1'b0;
            state_next = RESP;
          end else if (req_funct3 == 3'b010) begin
            we_raw     = 1'b1;
            rdata_next = 32'h0;
            err_next   = 1'b0;
            state_next = RESP;
          end else begin
            merged_next = merged_word;
            addr_next   = {req_addr[31:2], 2'b00};
            state_next  = RMW;
          end
        end
      end
      RMW: begin
        we_raw     = 1'b1;
        rdata_next = 32'h0;
        err_next   = 1'b0;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The write strobe is cut off combinationally while reset is asserted.
  always_comb begin
    mem_we     = we_raw && rst_n;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  // State register and the latched response / RMW data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      addr_q   <= 32'h0;
      merged_q <= 32'h0;
    end else begin
      state    <= state_next;
      rdata_q  <= rdata_next;
      err_q    <= err_next;
      addr_q   <= addr_next;
      merged_q <= merged_next;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Scoreboarded bench for lsu_dmem_master: a byte-level reference model
// predicts every response, a monitor checks responses as they appear, and
// the final memory image is compared against the model's memory.
module tb_lsu_dmem_master;

  localparam int MEM_WORDS = 1024;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] dmem     [0:MEM_WORDS-1];
  logic [31:0] init_img [0:MEM_WORDS-1];
  logic [31:0] ref_mem  [0:MEM_WORDS-1];
  bit          mem_loaded;
  int          cycle;
  int          total;
  int          bad;

  lsu_dmem_master #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure response latency.
  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Memory model: combinational read, posedge write, loaded from init_img first.
  assign mem_rd = dmem[mem_a[11:2]];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= init_img[i];
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      dmem[mem_a[11:2]] <= mem_wd;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: byte-addressed arithmetic on a word array.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output bit e, output int lat);
    int          size;
    int          sh;
    logic [31:0] word;
    logic [31:0] val;
    logic [31:0] mask;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    e = (size == 0) || (we && f3 > 3'd2);
    if (!e) e = ((addr % size) != 0) || (longint'(addr) >= 4 * longint'(MEM_WORDS));
    rd  = 32'h0;
    lat = 1;
    if (!e) begin
      word = ref_mem[addr / 4];
      sh   = 8 * int'(addr % 4);
      if (!we) begin
        val = word >> sh;
        if (size == 1) val = (f3 == 3'd0) ? 32'($signed(val[7:0])) : (val & 32'hFF);
        if (size == 2) val = (f3 == 3'd1) ? 32'($signed(val[15:0])) : (val & 32'hFFFF);
        rd = val;
      end else begin
        mask = (size == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * size)) - 1) << sh);
        ref_mem[addr / 4] = (word & ~mask) | ((wd << sh) & mask);
        lat = (size == 4) ? 1 : 2;
      end
    end
  endtask

  // Issue one request; expectation comes from the model or, if given, a constant.
  task automatic apply_stimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input bit use_exp = 0,
                                input logic [31:0] exp_rd = 0, input bit exp_e = 0);
    int          guard;
    logic [31:0] m_rd;
    bit          m_e;
    int          m_lat;
    exp_t        x;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check_output("ready_timeout", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    model(we, f3, addr, wd, m_rd, m_e, m_lat);
    x.rdata = use_exp ? exp_rd : m_rd;
    x.err   = use_exp ? exp_e : m_e;
    x.lat   = m_lat;
    x.acc   = cycle;
    sb_q.push_back(x);
    #1;
    check_output("we_accept", {31'h0, mem_we}, {31'h0, (we && !m_e && m_lat == 1)});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_output("we_rmw", {31'h0, mem_we}, {31'h0, (we && !m_e && m_lat == 2)});
  endtask

  // Monitor: pop and compare whenever a response is presented.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_resp", 32'h1, 32'h0);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        check_output("resp_rdata", resp_rdata, x.rdata);
        check_output("resp_err", {31'h0, resp_err}, {31'h0, x.err});
        check_output("latency", 32'(cycle - x.acc), 32'(x.lat));
      end
    end
  end

  initial begin
    int          guard;
    logic [31:0] a;
    total      = 0;
    bad        = 0;
    mem_loaded = 1'b0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) init_img[i] = $urandom;
    init_img[4] = 32'h8081_F2A3;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_img[i];

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("rst_we", {31'h0, mem_we}, 32'h0);
    check_output("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_output("rst_rdata", resp_rdata, 32'h0);
    check_output("rst_err", {31'h0, resp_err}, 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_ready", {31'h0, req_ready}, 32'h1);

    // Loads with known constants.
    apply_stimulus(0, 3'b010, 32'h10, 32'h0, 1, 32'h8081_F2A3, 0);
    apply_stimulus(0, 3'b000, 32'h11, 32'h0, 1, 32'hFFFF_FFF2, 0);
    apply_stimulus(0, 3'b100, 32'h11, 32'h0, 1, 32'h0000_00F2, 0);
    apply_stimulus(0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFF_8081, 0);
    apply_stimulus(0, 3'b101, 32'h12, 32'h0, 1, 32'h0000_8081, 0);

    // SB: RMW write of the merged word one cycle after accept.
    apply_stimulus(1, 3'b000, 32'h13, 32'h0000_0055, 1, 32'h0, 0);
    check_output("sb_merged_wd", mem_wd, 32'h5581_F2A3);
    apply_stimulus(0, 3'b010, 32'h10, 32'h0, 1, 32'h5581_F2A3, 0);

    // SW then reload.
    apply_stimulus(1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1, 32'h0, 0);
    apply_stimulus(0, 3'b010, 32'h20, 32'h0, 1, 32'hDEAD_BEEF, 0);

    // Error cases: misaligned half, misaligned word store, out of range, bad funct3.
    apply_stimulus(0, 3'b001, 32'h21, 32'h0, 1, 32'h0, 1);
    apply_stimulus(1, 3'b010, 32'h22, 32'h1234_5678, 1, 32'h0, 1);
    apply_stimulus(0, 3'b010, 32'h1000, 32'h0, 1, 32'h0, 1);
    apply_stimulus(0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1);
    apply_stimulus(1, 3'b100, 32'h4, 32'h0, 1, 32'h0, 1);

    // SH aborted by reset during RMW: no write, no response.
    apply_stimulus(1, 3'b010, 32'h40, 32'h1234_5678, 1, 32'h0, 0);
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h40;
    req_wdata  = 32'h0000_ABCD;
    @(posedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_we", {31'h0, mem_we}, 32'h0);
    check_output("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("abort_ready", {31'h0, req_ready}, 32'h1);
    apply_stimulus(0, 3'b010, 32'h40, 32'h0, 1, 32'h1234_5678, 0);

    // Randomized traffic, mostly in a small window plus the range boundary.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'(4 * MEM_WORDS - 4 + $urandom_range(0, 7));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 255));
      endcase
      apply_stimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    // Drain outstanding responses.
    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_output("drain", 32'(sb_q.size()), 32'h0);

    // Final memory image must match the model.
    @(negedge clk);
    for (int i = 0; i < MEM_WORDS; i++) check_output("mem_image", dmem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
